mips_bus_arbiter: RTL and testbench



---
 rtl/mips_bus_arbiter_pkg.sv | 21 ++
 rtl/mips_bus_arbiter_if.sv | 21 ++
 rtl/mips_bus_arbiter_rr_select.sv | 22 ++
 rtl/mips_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_mips_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types for the two-master Avalon-MM arbiter: owner encoding and the
// round-robin pointer.
package mips_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_M0   = 2'd1,
    OWNER_M1   = 2'd2
  } owner_t;

  // Last master to finish (or time out) a transfer; it loses the next tie.
  typedef enum logic {
    RR_M0 = 1'b0,
    RR_M1 = 1'b1
  } rr_t;

  function automatic rr_t rr_of(input owner_t o);
    return (o == OWNER_M1) ? RR_M1 : RR_M0;
  endfunction

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// One Avalon-MM link (address/strobes/data out of the master, stall and read
// data back). The arbiter takes two slave-side links and one master-side link.
interface mips_bus_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_arbiter_rr_select.sv
// Combinational round-robin picker used while the bus is idle: a lone requester
// wins outright, a tie goes to whichever master did not own the bus last.
module bus_rr_select
  import mips_bus_arbiter_pkg::*;
(
  input  logic   m0_req_i,
  input  logic   m1_req_i,
  input  rr_t    last_owner_i,
  output owner_t owner_o
);

  always_comb begin
    owner_o = OWNER_NONE;
    if (m0_req_i && m1_req_i)
      owner_o = (last_owner_i == RR_M1) ? OWNER_M0 : OWNER_M1;
    else if (m0_req_i)
      owner_o = OWNER_M0;
    else if (m1_req_i)
      owner_o = OWNER_M1;
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter for a single Avalon-MM slave: whole-transfer round-robin
// grants, per-master read-data hold registers and an optional stall timeout.
module mips_bus_arbiter
  import mips_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  mips_bus_arbiter_if.slave   m0,
  mips_bus_arbiter_if.slave   m1,
  mips_bus_arbiter_if.master  s,
  output logic                bus_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  owner_t             owner_q, owner_d, pick;
  rr_t                last_q, last_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               err_q, err_d;
  logic [31:0]        hold0_q, hold0_d, hold1_q, hold1_d;
  logic               m0_req, m1_req, cur_req;
  logic               done, timeout, take0, take1;

  assign m0_req  = m0.read | m0.write;
  assign m1_req  = m1.read | m1.write;
  assign cur_req = (owner_q == OWNER_M0) ? m0_req : m1_req;

  bus_rr_select u_sel (
    .m0_req_i     (m0_req),
    .m1_req_i     (m1_req),
    .last_owner_i (last_q),
    .owner_o      (pick)
  );

  // Slave mux: idle bus drives all zeros.
  always_comb begin
    s.address    = '0;
    s.read       = 1'b0;
    s.write      = 1'b0;
    s.writedata  = '0;
    s.byteenable = '0;
    unique case (owner_q)
      OWNER_M0: begin
        s.address    = m0.address;
        s.read       = m0.read;
        s.write      = m0.write;
        s.writedata  = m0.writedata;
        s.byteenable = m0.byteenable;
      end
      OWNER_M1: begin
        s.address    = m1.address;
        s.read       = m1.read;
        s.write      = m1.write;
        s.writedata  = m1.writedata;
        s.byteenable = m1.byteenable;
      end
      default: ;
    endcase
  end

  assign m0.waitrequest = (owner_q == OWNER_M0) ? s.waitrequest : 1'b1;
  assign m1.waitrequest = (owner_q == OWNER_M1) ? s.waitrequest : 1'b1;

  assign done    = (owner_q != OWNER_NONE) & (s.read | s.write) & ~s.waitrequest;
  assign timeout = (TIMEOUT_CYCLES != 0) && (owner_q != OWNER_NONE) && s.waitrequest &&
                   (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Read word is passed through in the done cycle and held for the next one.
  assign take0 = done & (owner_q == OWNER_M0) & s.read;
  assign take1 = done & (owner_q == OWNER_M1) & s.read;
  assign m0.readdata = take0 ? s.readdata : hold0_q;
  assign m1.readdata = take1 ? s.readdata : hold1_q;
  assign hold0_d = take0 ? s.readdata : hold0_q;
  assign hold1_d = take1 ? s.readdata : hold1_q;

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q;
    if (owner_q == OWNER_NONE) begin
      owner_d = pick;
    end else if (done) begin
      owner_d = OWNER_NONE;
      last_d  = rr_of(owner_q);
    end else if (!cur_req) begin
      // Abandoned transfer does not count as this master's turn.
      owner_d = OWNER_NONE;
    end else if (timeout) begin
      owner_d = OWNER_NONE;
      last_d  = rr_of(owner_q);
      err_d   = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (owner_d != owner_q)
      stall_cnt_d = '0;
    else if ((owner_q != OWNER_NONE) && s.waitrequest)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWNER_NONE;
      last_q      <= RR_M1;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      hold0_q     <= '0;
      hold1_q     <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
    end
  end

  assign bus_error = err_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed scenarios plus randomized traffic, each cycle compared against a
// transfer-level reference model of the arbiter.
module tb_mips_bus_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  logic bus_error;

  mips_bus_arbiter_if m0_if ();
  mips_bus_arbiter_if m1_if ();
  mips_bus_arbiter_if s_if ();

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: owner 0=idle, 1=M0, 2=M1; last is 1 or 2.
  int          own, last, cnt;
  bit          err;
  logic [31:0] hold [2];
  bit          mdone [2];
  logic [31:0] cap_rd0, cap_saddr, cap_swd;
  logic        cap_w0, cap_srd, cap_swr, cap_err;
  logic [3:0]  cap_sbe;

  task automatic model_reset();
    own = 0; last = 2; cnt = 0; err = 0;
    hold[0] = '0; hold[1] = '0;
  endtask

  function automatic logic m_rd(input int i);
    return (i == 0) ? m0_if.read : m1_if.read;
  endfunction
  function automatic logic m_wr(input int i);
    return (i == 0) ? m0_if.write : m1_if.write;
  endfunction

  task automatic set_m(input int i, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (i == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.writedata = wd; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.writedata = wd; m1_if.byteenable = be;
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_rd, e_wr, done, sw;
    logic [31:0] e_rdat [2];
    logic        e_wait [2];
    int          nxt;
    @(negedge clk);
    e_addr = '0; e_wd = '0; e_be = '0; e_rd = 0; e_wr = 0;
    sw = s_if.waitrequest;
    if (own == 1) begin
      e_addr = m0_if.address; e_wd = m0_if.writedata; e_be = m0_if.byteenable;
      e_rd = m0_if.read; e_wr = m0_if.write;
    end else if (own == 2) begin
      e_addr = m1_if.address; e_wd = m1_if.writedata; e_be = m1_if.byteenable;
      e_rd = m1_if.read; e_wr = m1_if.write;
    end
    done = (own != 0) && (e_rd || e_wr) && !sw;
    for (int i = 0; i < 2; i++) begin
      e_wait[i] = (own == i + 1) ? sw : 1'b1;
      e_rdat[i] = (done && own == i + 1 && e_rd) ? s_if.readdata : hold[i];
      mdone[i]  = done && (own == i + 1);
    end
    check("s_address", s_if.address, e_addr);
    check("s_read", 32'(s_if.read), 32'(e_rd));
    check("s_write", 32'(s_if.write), 32'(e_wr));
    check("s_writedata", s_if.writedata, e_wd);
    check("s_byteenable", 32'(s_if.byteenable), 32'(e_be));
    check("m0_waitrequest", 32'(m0_if.waitrequest), 32'(e_wait[0]));
    check("m1_waitrequest", 32'(m1_if.waitrequest), 32'(e_wait[1]));
    check("m0_readdata", m0_if.readdata, e_rdat[0]);
    check("m1_readdata", m1_if.readdata, e_rdat[1]);
    check("bus_error", 32'(bus_error), 32'(err));
    cap_rd0 = m0_if.readdata; cap_w0 = m0_if.waitrequest; cap_srd = s_if.read;
    cap_swr = s_if.write; cap_saddr = s_if.address; cap_swd = s_if.writedata;
    cap_sbe = s_if.byteenable; cap_err = bus_error;
    if (reset) begin
      model_reset();
    end else begin
      nxt = own;
      if (own == 0) begin
        if ((m_rd(0) | m_wr(0)) && (m_rd(1) | m_wr(1))) nxt = (last == 1) ? 2 : 1;
        else if (m_rd(0) | m_wr(0)) nxt = 1;
        else if (m_rd(1) | m_wr(1)) nxt = 2;
      end else if (done) begin
        nxt = 0; last = own;
      end else if (!(m_rd(own - 1) | m_wr(own - 1))) begin
        nxt = 0;
      end else if (TO != 0 && cnt == TO - 1 && sw) begin
        nxt = 0; last = own; err = 1;
      end
      if (done && e_rd) hold[own - 1] = s_if.readdata;
      if (nxt != own) cnt = 0;
      else if (own != 0 && sw) cnt++;
      own = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  bit act [2];

  initial begin
    reset = 1'b1;
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
    s_if.waitrequest = 1'b0;
    s_if.readdata = '0;
    @(posedge clk);
    #1;
    model_reset();
    step();
    check("rst_m0_wait", 32'(cap_w0), 32'd1);
    check("rst_m0_rdata", cap_rd0, 32'h0);
    reset = 1'b0;

    // Single M0 read, zero-wait slave.
    set_m(0, 1, 0, 32'hBFC0_0000, '0, 4'hF);
    s_if.readdata = 32'h3C02_0005;
    step();
    check("A_wait_req_cycle", 32'(cap_w0), 32'd1);
    step();
    check("A_wait_grant", 32'(cap_w0), 32'd0);
    check("A_rdata_done", cap_rd0, 32'h3C02_0005);
    check("A_sread", 32'(cap_srd), 32'd1);
    set_m(0, 0, 0, '0, '0, '0);
    s_if.readdata = 32'h1111_1111;
    step();
    check("A_rdata_hold", cap_rd0, 32'h3C02_0005);
    check("A_sread_once", 32'(cap_srd), 32'd0);

    // Tie after reset: M0 first, M1 after a gap, next tie M0 again.
    reset = 1'b1; step(); reset = 1'b0;
    set_m(0, 1, 0, 32'h0000_00A0, '0, 4'hF);
    set_m(1, 0, 1, 32'h0000_00B0, 32'h55, 4'hF);
    step();
    step();
    check("B_first_m0", 32'(cap_srd), 32'd1);
    set_m(0, 0, 0, '0, '0, '0);
    step();
    check("B_gap", 32'(cap_srd | cap_swr), 32'd0);
    step();
    check("B_then_m1", 32'(cap_swr), 32'd1);
    set_m(1, 0, 0, '0, '0, '0);
    set_m(0, 1, 0, 32'h0000_00A4, '0, 4'hF);
    set_m(1, 0, 1, 32'h0000_00B4, 32'h66, 4'hF);
    step();
    step();
    check("B_tie2_m0", 32'(cap_srd), 32'd1);
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
    step();

    // M1 write with a 3-cycle slave stall.
    set_m(1, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
    s_if.waitrequest = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("C_wdata", cap_swd, 32'hDEAD_BEEF);
      check("C_be", 32'(cap_sbe), 32'h3);
      check("C_m0_wait", 32'(cap_w0), 32'd1);
      check("C_m0_rdata", cap_rd0, 32'h1111_1111);
    end
    s_if.waitrequest = 1'b0;
    step();
    set_m(1, 0, 0, '0, '0, '0);
    step();

    // Timeout with both masters requesting.
    set_m(0, 1, 0, 32'h0000_0200, '0, 4'hF);
    set_m(1, 1, 0, 32'h0000_0300, '0, 4'hF);
    s_if.waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) step();
    step();
    check("D_err", 32'(cap_err), 32'd1);
    check("D_idle", 32'(cap_srd), 32'd0);
    step();
    check("D_next_m1", cap_saddr, 32'h0000_0300);
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
    s_if.waitrequest = 1'b0;
    step();

    // Reset during an M0 stall.
    set_m(0, 1, 0, 32'h0000_0400, '0, 4'hF);
    s_if.waitrequest = 1'b1;
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    step();
    check("E_sread", 32'(cap_srd), 32'd0);
    check("E_err", 32'(cap_err), 32'd0);
    check("E_rdata", cap_rd0, 32'h0);
    set_m(0, 0, 0, '0, '0, '0);
    step(); step();

    // M0 abandons mid-stall: last_owner untouched so M0 still wins the next tie.
    set_m(0, 1, 0, 32'h0000_0500, '0, 4'hF);
    step(); step();
    set_m(0, 0, 0, '0, '0, '0);
    step();
    s_if.waitrequest = 1'b0;
    set_m(0, 1, 0, 32'h0000_0504, '0, 4'hF);
    set_m(1, 0, 1, 32'h0000_0600, 32'h77, 4'hF);
    step(); step();
    check("F_tie_m0", 32'(cap_srd), 32'd1);
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
    step();

    // Randomized traffic.
    act[0] = 0; act[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (mdone[i] || (act[i] && $urandom_range(0, 31) == 0)) begin
          act[i] = 0;
          set_m(i, 0, 0, '0, '0, '0);
        end else if (!act[i] && $urandom_range(0, 9) < 4) begin
          act[i] = 1;
          case ($urandom_range(0, 4))
            0, 1:    set_m(i, 1, 0, $urandom, $urandom, 4'($urandom));
            2, 3:    set_m(i, 0, 1, $urandom, $urandom, 4'($urandom));
            default: set_m(i, 1, 1, $urandom, $urandom, 4'($urandom));
          endcase
        end
      end
      s_if.waitrequest = ($urandom_range(0, 9) < 4);
      s_if.readdata = $urandom;
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
